uart_result_tx: RTL and testbench

- Serial transmitter for the result of the SAD matching pipeline; it is the far end of the control unit's UARTsend / UARTsendComplete handshake.
- Accepts a result code (MATCH / NOT_MATCH) plus the match coordinate, serialises a short 8N1 byte message onto a UART line, then returns a one-cycle completion pulse to the control unit.

---
 rtl/uart_result_tx.sv | 136 +++++++++++++
 tb/tb_uart_result_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// 8N1 serial transmitter for the SAD match result: a 5-byte MATCH message
// ('M', x, y) or a single 'N' byte, acknowledged with a one-cycle pulse.
module uart_result_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HDR_MATCH    = 8'h4D,
    parameter logic [7:0]  HDR_NOMATCH  = 8'h4E
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] UARTsend,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       UARTsendComplete,
    output logic       busy,
    output logic       tx
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, WAIT_OFF} state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic          is_match;
    logic [9:0]    x_q;
    logic [8:0]    y_q;
    logic [7:0]    shreg;

    logic          bit_done;
    logic          req_valid;
    logic          req_off;
    logic [2:0]    next_idx;
    logic [2:0]    last_idx;
    logic [7:0]    next_byte;

    assign bit_done  = (bit_cnt == BIT_LAST);
    assign req_valid = (UARTsend == 2'd1) || (UARTsend == 2'd2);
    assign req_off   = !req_valid;
    assign next_idx  = byte_idx + 3'd1;
    assign last_idx  = is_match ? 3'd4 : 3'd0;

    // Bytes 1..4 of a MATCH message come from the coordinates latched at acceptance.
    always_comb begin
        next_byte = HDR_MATCH;
        case (next_idx)
            3'd1:    next_byte = {6'b0, x_q[9:8]};
            3'd2:    next_byte = x_q[7:0];
            3'd3:    next_byte = {7'b0, y_q[8]};
            3'd4:    next_byte = y_q[7:0];
            default: next_byte = HDR_MATCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            bit_cnt          <= '0;
            bit_idx          <= '0;
            byte_idx         <= '0;
            is_match         <= 1'b0;
            x_q              <= '0;
            y_q              <= '0;
            shreg            <= '0;
            tx               <= 1'b1;
            busy             <= 1'b0;
            UARTsendComplete <= 1'b0;
        end else begin
            if (state == START || state == DATA || state == STOP)
                bit_cnt <= bit_done ? '0 : bit_cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_match <= (UARTsend == 2'd1);
                        x_q      <= x;
                        y_q      <= y;
                        shreg    <= (UARTsend == 2'd1) ? HDR_MATCH : HDR_NOMATCH;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (byte_idx == last_idx) begin
                            UARTsendComplete <= 1'b1;
                            state            <= DONE;
                        end else begin
                            byte_idx <= next_idx;
                            shreg    <= next_byte;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end
                end
                DONE: begin
                    UARTsendComplete <= 1'b0;
                    busy             <= 1'b0;
                    state            <= WAIT_OFF;
                end
                WAIT_OFF: begin
                    // A level-held request must drop before another message is taken.
                    if (req_off)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx: frame waveform, decoded bytes, busy/complete
// timing, held requests, reserved code and mid-message reset.
module tb_uart_result_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] req4, req2;
    logic [9:0] x4, x2;
    logic [8:0] y4, y2;
    logic       cmp4, busy4, tx4;
    logic       cmp2, busy2, tx2;

    always #5 clock = ~clock;

    uart_result_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clock(clock), .reset(reset), .UARTsend(req4), .x(x4), .y(y4),
        .UARTsendComplete(cmp4), .busy(busy4), .tx(tx4)
    );

    uart_result_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clock(clock), .reset(reset), .UARTsend(req2), .x(x2), .y(y2),
        .UARTsendComplete(cmp2), .busy(busy2), .tx(tx2)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       txs[0:511];
    int         busy_cnt, pulse_at, pulse_cnt, wave_err;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples n cycles after a request was driven; builds the expected line
    // waveform from exp_q and decodes bytes at bit centres.
    task automatic capture(input bit sel, input int c, input int n, input int hold, input bit toggle);
        int         nb, f, j, bi, base;
        logic       t, b, p, e;
        logic [7:0] v;
        nb = exp_q.size();
        busy_cnt = 0; pulse_at = 0; pulse_cnt = 0; wave_err = 0;
        got_q.delete();
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            t = sel ? tx2 : tx4;
            b = sel ? busy2 : busy4;
            p = sel ? cmp2 : cmp4;
            txs[k] = t;
            if (b === 1'b1) busy_cnt++;
            if (p === 1'b1) begin
                pulse_cnt++;
                if (pulse_at == 0) pulse_at = k;
            end
            if (k <= nb * 10 * c) begin
                f  = (k - 1) / c;
                j  = f / 10;
                bi = f % 10;
                e  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : exp_q[j][bi-1];
            end else begin
                e = 1'b1;
            end
            if (t !== e) wave_err++;
            if (k == hold) begin
                req4 = 2'd0;
                req2 = 2'd0;
            end
            if (toggle) begin
                x4 = ~x4;
                y4 = ~y4;
            end
        end
        if (n >= nb * 10 * c) begin
            for (j = 0; j < nb; j++) begin
                base = 1 + j * 10 * c;
                for (bi = 0; bi < 8; bi++)
                    v[bi] = txs[base + (1 + bi) * c + c / 2];
                got_q.push_back(v);
            end
        end
    endtask

    task automatic chk_bytes(input string tag);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        req4 = 2'd0; req2 = 2'd0;
        x4 = '0; y4 = '0; x2 = '0; y2 = '0;
        repeat (3) @(negedge clock);
        chk("rst_tx4", tx4, 1);
        chk("rst_busy4", busy4, 0);
        chk("rst_cmp4", cmp4, 0);
        chk("rst_tx2", tx2, 1);

        // Request while reset is still high must be ignored
        req4 = 2'd1; x4 = 10'h2A5; y4 = 9'h13C;
        @(negedge clock);
        chk("rst_prio_busy", busy4, 0);
        chk("rst_prio_tx", tx4, 1);

        // Held into the first non-reset edge: accepted there
        reset = 1'b0;
        exp_q = '{8'h4D, 8'h02, 8'hA5, 8'h01, 8'h3C};
        capture(0, 4, 210, 1, 0);
        chk_bytes("match1");
        chk("match1_wave", wave_err, 0);
        chk("match1_busy", busy_cnt, 201);
        chk("match1_pulse_at", pulse_at, 201);
        chk("match1_pulse_cnt", pulse_cnt, 1);

        // NOT_MATCH held for 300 cycles: one frame only
        req4 = 2'd2;
        exp_q = '{8'h4E};
        capture(0, 4, 300, 300, 0);
        chk_bytes("nomatch");
        chk("nomatch_wave", wave_err, 0);
        chk("nomatch_busy", busy_cnt, 41);
        chk("nomatch_pulse_at", pulse_at, 41);
        chk("nomatch_pulse_cnt", pulse_cnt, 1);
        @(negedge clock);
        req4 = 2'd2;
        capture(0, 4, 50, 1, 0);
        chk_bytes("nomatch_re");
        chk("nomatch_re_pulse_at", pulse_at, 41);

        // Coordinates toggling every cycle after acceptance
        req4 = 2'd1; x4 = 10'h155; y4 = 9'h0AA;
        exp_q = '{8'h4D, 8'h01, 8'h55, 8'h00, 8'hAA};
        capture(0, 4, 210, 1, 1);
        chk_bytes("toggle");
        chk("toggle_wave", wave_err, 0);

        // Reset in the middle of byte 1
        req4 = 2'd1; x4 = 10'h2A5; y4 = 9'h13C;
        exp_q = '{8'h4D, 8'h02, 8'hA5, 8'h01, 8'h3C};
        capture(0, 4, 60, 1, 0);
        chk("abort_wave", wave_err, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_tx", tx4, 1);
        chk("abort_busy", busy4, 0);
        chk("abort_cmp", cmp4, 0);
        reset = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clock);
            if (cmp4 !== 1'b0 || busy4 !== 1'b0 || tx4 !== 1'b1) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        req4 = 2'd1; x4 = 10'h0C3; y4 = 9'h15A;
        exp_q = '{8'h4D, 8'h00, 8'hC3, 8'h01, 8'h5A};
        capture(0, 4, 210, 1, 0);
        chk_bytes("after_abort");
        chk("after_abort_wave", wave_err, 0);
        chk("after_abort_pulse_at", pulse_at, 201);

        // Reserved code is ignored
        req4 = 2'd3;
        exp_q.delete();
        capture(0, 4, 25, 20, 0);
        chk("rsvd_wave", wave_err, 0);
        chk("rsvd_busy", busy_cnt, 0);
        chk("rsvd_pulse", pulse_cnt, 0);

        // Two cycles per bit, all-ones coordinates
        req2 = 2'd1; x2 = 10'h3FF; y2 = 9'h1FF;
        exp_q = '{8'h4D, 8'h03, 8'hFF, 8'h01, 8'hFF};
        capture(1, 2, 110, 1, 0);
        chk_bytes("c2");
        chk("c2_wave", wave_err, 0);
        chk("c2_busy", busy_cnt, 101);
        chk("c2_pulse_at", pulse_at, 101);
        chk("c2_pulse_cnt", pulse_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
